// File: rtl/fpu_half_pkg.sv
// Shared binary16 constants, rounding-mode encodings, flag indices and the
// normalized-operand payload carried between the pipeline stages.
package fpu_half_pkg;

  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;
  localparam int FRAC_W   = 10;

  typedef enum logic [2:0] {
    FRM_RNE = 3'b000,
    FRM_RTZ = 3'b001,
    FRM_RDN = 3'b010,
    FRM_RUP = 3'b011,
    FRM_RMM = 3'b100
  } frm_e;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;
  localparam logic [14:0] MAXF = 15'h7BFF;

  // Hidden bit is implied by expo != 0, so only bits [22:0] are kept.
  typedef struct packed {
    logic        sign;
    logic        special;
    logic        zero;
    logic        nv;
    logic [2:0]  frm;
    logic [8:0]  expo;
    logic [22:0] mant;
    logic        sticky;
    logic [15:0] special_val;
  } norm_t;

endpackage

// File: rtl/fmadd_round_half.sv
// Combinational round/pack of a normalized operand into binary16 plus flags.
// FMADD_NORM_FLUSH_DENORM_EN replaces subnormal results with signed zero.
module fmadd_round_half
  import fpu_half_pkg::*;
(
  input  logic        sign_i,
  input  logic        special_i,
  input  logic        zero_i,
  input  logic        nv_i,
  input  logic [2:0]  frm_i,
  input  logic [8:0]  expo_i,
  input  logic [22:0] mant_i,
  input  logic        sticky_i,
  input  logic [15:0] special_val_i,
  output logic [15:0] result_o,
  output logic [4:0]  flags_o
);

  logic        g, st, lsb, inc, of, nx, uf, to_inf;
  logic [18:0] mag;
  logic [8:0]  fexp;

  always_comb begin
    g   = mant_i[12];
    st  = (|mant_i[11:0]) | sticky_i;
    lsb = mant_i[13];
    case (frm_e'(frm_i))
      FRM_RTZ: inc = 1'b0;
      FRM_RDN: inc = sign_i & (g | st);
      FRM_RUP: inc = ~sign_i & (g | st);
      FRM_RMM: inc = g;
      default: inc = g & (st | lsb);
    endcase
    // Fraction carry ripples into the exponent; subnormal 0x3FF+1 lands on expo 1.
    mag    = {expo_i, mant_i[22 -: FRAC_W]} + 19'(inc);
    fexp   = mag[18:FRAC_W];
    of     = fexp >= 9'(EXP_MAX);
    nx     = g | st | of;
    uf     = nx & (fexp == 9'd0);
    to_inf = (frm_i == FRM_RNE) | (frm_i == FRM_RMM) |
             ((frm_i == FRM_RUP) & ~sign_i) | ((frm_i == FRM_RDN) & sign_i);

    result_o = {sign_i, mag[14:0]};
    if (of) result_o = to_inf ? {sign_i, PINF[14:0]} : {sign_i, MAXF};
`ifdef FMADD_NORM_FLUSH_DENORM_EN
    if (fexp == 9'd0 && mag[FRAC_W-1:0] != '0) begin
      result_o = {sign_i, 15'b0};
      uf       = 1'b1;
      nx       = 1'b1;
    end
`endif
    flags_o         = '0;
    flags_o[FLG_NV] = nv_i;
    flags_o[FLG_DZ] = 1'b0;
    flags_o[FLG_OF] = of;
    flags_o[FLG_UF] = uf;
    flags_o[FLG_NX] = nx;

    if (zero_i) begin
      result_o = {sign_i, 15'b0};
      flags_o  = '0;
    end
    if (special_i) begin
      result_o = special_val_i;
      flags_o  = {nv_i, 4'b0};
    end
  end

endmodule

// File: rtl/fmadd_norm_round_pipe.sv
// Two-stage FMADD back end: normalize/denormalize, then round and pack binary16.
// Optional FMADD_NORM_FLUSH_DENORM_EN flushes subnormal results to zero.
module fmadd_norm_round_pipe
  import fpu_half_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int POS_W  = 5,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [POS_W-1:0]  in_lzd_pos,
  input  logic              in_special,
  input  logic [15:0]       in_special_val,
  input  logic              in_nv,
  input  logic [2:0]        frm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [4:0]        out_flags
);

  logic [2:1]              vld_q;
  logic                    en1, en2;
  norm_t                   s1_d, s1_q, s2_q;
  logic signed [EXP_W:0]   e_s;
  logic signed [EXP_W+1:0] rsh_full;
  logic [4:0]              rsh;
  logic [MANT_W-1:0]       shl;
  logic [47:0]             wide;

  assign en2       = ~vld_q[2] | out_ready;
  assign en1       = ~vld_q[1] | en2;
  assign in_ready  = en1;
  assign out_valid = vld_q[2];

  assign e_s = $signed({in_exp[EXP_W-1], in_exp})
             + $signed({{(EXP_W+1-POS_W){1'b0}}, in_lzd_pos})
             - $signed((EXP_W+1)'(22));
  assign shl = in_mant << (POS_W'(23) - in_lzd_pos);

  // Subnormal right shift saturates at 25: everything past that is pure sticky.
  assign rsh_full = $signed((EXP_W+2)'(1)) - $signed({e_s[EXP_W], e_s});
  assign rsh      = (rsh_full > $signed((EXP_W+2)'(25))) ? 5'd25 : rsh_full[4:0];
  assign wide     = 48'({shl, 25'b0} >> rsh);

  always_comb begin
    s1_d             = '0;
    s1_d.sign        = in_sign;
    s1_d.special     = in_special;
    s1_d.special_val = in_special_val;
    s1_d.nv          = in_nv;
    s1_d.frm         = frm;
    s1_d.zero        = (in_mant == '0);
    if (!e_s[EXP_W] && e_s != '0) begin
      s1_d.expo = e_s;
      s1_d.mant = shl[22:0];
    end else begin
      s1_d.expo   = '0;
      s1_d.mant   = wide[47:25];
      s1_d.sticky = |wide[24:0];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      if (en1) begin
        vld_q[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (en2) begin
        vld_q[2] <= vld_q[1];
        if (vld_q[1]) s2_q <= s1_q;
      end
    end
  end

  fmadd_round_half u_round (
    .sign_i        (s2_q.sign),
    .special_i     (s2_q.special),
    .zero_i        (s2_q.zero),
    .nv_i          (s2_q.nv),
    .frm_i         (s2_q.frm),
    .expo_i        (s2_q.expo),
    .mant_i        (s2_q.mant),
    .sticky_i      (s2_q.sticky),
    .special_val_i (s2_q.special_val),
    .result_o      (out_result),
    .flags_o       (out_flags)
  );

endmodule

// File: tb/tb_fmadd_norm_round_pipe.sv
// Directed bench for fmadd_norm_round_pipe; expectations track
// FMADD_NORM_FLUSH_DENORM_EN when the bench is built with it.
module tb_fmadd_norm_round_pipe;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic [4:0]  in_lzd_pos = '0;
  logic        in_special = 1'b0;
  logic [15:0] in_special_val = '0;
  logic        in_nv = 1'b0;
  logic [2:0]  frm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [4:0]  out_flags;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [4:0]  p;
    logic [2:0]  rm;
    logic [15:0] r;
    logic [4:0]  f;
  } vec_t;

  fmadd_norm_round_pipe dut (
    .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_lzd_pos(in_lzd_pos),
    .in_special(in_special), .in_special_val(in_special_val), .in_nv(in_nv), .frm(frm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drives one operand into an empty pipe and returns the first result seen.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic [4:0] p, input logic [2:0] rm, input logic sp,
                        input logic [15:0] spv, input logic nv,
                        output logic [15:0] r, output logic [4:0] f, output int lat);
    int c0;
    bit got;
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_lzd_pos = p; frm = rm;
    in_special = sp; in_special_val = spv; in_nv = nv;
    in_valid = 1'b1; out_ready = 1'b1;
    c0 = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got = 0; lat = -1; r = 'x; f = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) begin
        got = 1; lat = cyc - c0; r = out_result; f = out_flags;
      end else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 16'h0000) begin fails++; $display("FAIL reset_result got=%h exp=0000", out_result); end
    checks++; if (out_flags !== 5'b0) begin fails++; $display("FAIL reset_flags got=%b exp=00000", out_flags); end
    rst_l = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] r; logic [4:0] f; int lat;
    run_op(1'b0, 8'd15, 24'h400000, 5'd22, 3'b000, 1'b0, 16'h0, 1'b0, r, f, lat);
    checks++; if (r !== 16'h3C00) begin fails++; $display("FAIL basic_result got=%h exp=3c00", r); end
    checks++; if (f !== 5'b0) begin fails++; $display("FAIL basic_flags got=%b exp=00000", f); end
    checks++; if (lat != 2) begin fails++; $display("FAIL basic_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_round();
    vec_t v[8];
    logic [15:0] r; logic [4:0] f; int lat;
    v[0] = '{1'b0, 8'd15, 24'h801000, 5'd23, 3'b000, 16'h4000, 5'b00001};
    v[1] = '{1'b0, 8'd15, 24'h801000, 5'd23, 3'b011, 16'h4001, 5'b00001};
    v[2] = '{1'b1, 8'd15, 24'h801000, 5'd23, 3'b010, 16'hC001, 5'b00001};
    v[3] = '{1'b0, 8'd15, 24'h803000, 5'd23, 3'b000, 16'h4002, 5'b00001};
    v[4] = '{1'b0, 8'd15, 24'h801000, 5'd23, 3'b100, 16'h4001, 5'b00001};
    v[5] = '{1'b0, 8'd15, 24'h801FFF, 5'd23, 3'b001, 16'h4000, 5'b00001};
    v[6] = '{1'b0, 8'd15, 24'h800001, 5'd23, 3'b011, 16'h4001, 5'b00001};
    v[7] = '{1'b1, 8'd15, 24'h800001, 5'd23, 3'b000, 16'hC000, 5'b00001};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].s, v[i].e, v[i].m, v[i].p, v[i].rm, 1'b0, 16'h0, 1'b0, r, f, lat);
      checks++;
      if (r !== v[i].r || f !== v[i].f) begin
        fails++; $display("FAIL round[%0d] got=%h/%b exp=%h/%b", i, r, f, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[8];
    logic [15:0] r; logic [4:0] f; int lat;
    v[0] = '{1'b0, 8'd30, 24'h800000, 5'd23, 3'b000, 16'h7C00, 5'b00101};
    v[1] = '{1'b0, 8'd30, 24'h800000, 5'd23, 3'b001, 16'h7BFF, 5'b00101};
    v[2] = '{1'b0, 8'd30, 24'h800000, 5'd23, 3'b010, 16'h7BFF, 5'b00101};
    v[3] = '{1'b1, 8'd30, 24'h800000, 5'd23, 3'b010, 16'hFC00, 5'b00101};
    v[4] = '{1'b1, 8'd30, 24'h800000, 5'd23, 3'b011, 16'hFBFF, 5'b00101};
    v[5] = '{1'b0, 8'd30, 24'h800000, 5'd23, 3'b100, 16'h7C00, 5'b00101};
    v[6] = '{1'b0, 8'd29, 24'hFFF000, 5'd23, 3'b000, 16'h7C00, 5'b00101};
    v[7] = '{1'b0, 8'd29, 24'hFFE000, 5'd23, 3'b001, 16'h7BFF, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].s, v[i].e, v[i].m, v[i].p, v[i].rm, 1'b0, 16'h0, 1'b0, r, f, lat);
      checks++;
      if (r !== v[i].r || f !== v[i].f) begin
        fails++; $display("FAIL overflow[%0d] got=%h/%b exp=%h/%b", i, r, f, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_subnormal();
    vec_t v[6];
    logic [15:0] r; logic [4:0] f; int lat;
`ifdef FMADD_NORM_FLUSH_DENORM_EN
    v[0] = '{1'b0, 8'd0,   24'h400000, 5'd22, 3'b000, 16'h0000, 5'b00011};
    v[1] = '{1'b0, 8'd0,   24'h400001, 5'd22, 3'b000, 16'h0000, 5'b00011};
    v[4] = '{1'b0, 8'hEC,  24'h400000, 5'd22, 3'b011, 16'h0000, 5'b00011};
`else
    v[0] = '{1'b0, 8'd0,   24'h400000, 5'd22, 3'b000, 16'h0200, 5'b00000};
    v[1] = '{1'b0, 8'd0,   24'h400001, 5'd22, 3'b000, 16'h0200, 5'b00011};
    v[4] = '{1'b0, 8'hEC,  24'h400000, 5'd22, 3'b011, 16'h0001, 5'b00011};
`endif
    v[2] = '{1'b0, 8'hFF,  24'hFFE000, 5'd23, 3'b000, 16'h0400, 5'b00001};
    v[3] = '{1'b0, 8'hEC,  24'h400000, 5'd22, 3'b000, 16'h0000, 5'b00011};
    v[5] = '{1'b1, 8'd15,  24'h000000, 5'd0,  3'b000, 16'h8000, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].s, v[i].e, v[i].m, v[i].p, v[i].rm, 1'b0, 16'h0, 1'b0, r, f, lat);
      checks++;
      if (r !== v[i].r || f !== v[i].f) begin
        fails++; $display("FAIL subnormal[%0d] got=%h/%b exp=%h/%b", i, r, f, v[i].r, v[i].f);
      end
    end
  endtask

  task automatic test_special();
    logic [15:0] r; logic [4:0] f; int lat;
    run_op(1'b0, 8'd15, 24'h400000, 5'd22, 3'b000, 1'b1, 16'h7E00, 1'b1, r, f, lat);
    checks++; if (r !== 16'h7E00 || f !== 5'b10000) begin fails++; $display("FAIL special_nan got=%h/%b exp=7e00/10000", r, f); end
    run_op(1'b1, 8'd15, 24'h801000, 5'd23, 3'b011, 1'b1, 16'hFC00, 1'b0, r, f, lat);
    checks++; if (r !== 16'hFC00 || f !== 5'b00000) begin fails++; $display("FAIL special_inf got=%h/%b exp=fc00/00000", r, f); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_r [4];
    int sent, rcv, k;
    logic acc;
    exp_r = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
    sent = 0; rcv = 0; k = 0;
    in_special = 1'b0; in_nv = 1'b0; in_sign = 1'b0; frm = 3'b000;
    in_mant = 24'h400000; in_lzd_pos = 5'd22;
    while (rcv < 4 && k < 40) begin
      @(negedge clk);
      out_ready = !(k >= 2 && k <= 4);
      in_valid  = (sent < 4);
      in_exp    = 8'(15 + sent);
      #1;
      if (k >= 2 && k <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          fails++; $display("FAIL bp_in_ready k=%0d got=%b/%0d exp=0/2", k, in_ready, sent);
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp_r[0] || out_flags !== 5'b0) begin
          fails++; $display("FAIL bp_hold k=%0d got=%b/%h/%b exp=1/%h/00000", k, out_valid, out_result, out_flags, exp_r[0]);
        end
      end
      if (out_valid && out_ready && rcv < 4) begin
        checks++;
        if (out_result !== exp_r[rcv]) begin
          fails++; $display("FAIL bp_order[%0d] got=%h exp=%h", rcv, out_result, exp_r[rcv]);
        end
        rcv++;
      end
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcv != 4) begin fails++; $display("FAIL bp_count got=%0d exp=4", rcv); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    @(negedge clk);
    out_ready = 1'b0; in_special = 1'b0; in_nv = 1'b0; frm = 3'b000;
    in_mant = 24'h400000; in_lzd_pos = 5'd22; in_exp = 8'd15; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_exp = 8'd16;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_full got=%b exp=1", out_valid); end
    rst_l = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 16'h0) begin fails++; $display("FAIL rstmid_clear got=%b/%h exp=0/0000", out_valid, out_result); end
    @(negedge clk);
    rst_l = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin fails++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_overflow();
    test_subnormal();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
